// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter in front of a single-ported data memory.
// Each access takes three cycles: IDLE (sample and grant), ACCESS (drive memory),
// DONE (one-cycle ack to the winner).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  port A (CPU) request fields
//   a_ack, a_rdata           port A completion pulse and read data
//   b_req/b_we/b_addr/b_wdata  port B (DMA/loader) request fields
//   b_ack, b_rdata           port B completion pulse and read data
//   mem_addr/mem_din/mem_we  memory request, driven only during ACCESS
//   mem_dout                 memory read data (combinational on mem_addr)
//   busy                     high whenever not IDLE
//   acc_cnt                  saturating count of completed accesses
module dm_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic             a_we,
  input  logic [11:2]      a_addr,
  input  logic [31:0]      a_wdata,
  output logic             a_ack,
  output logic [31:0]      a_rdata,
  input  logic             b_req,
  input  logic             b_we,
  input  logic [11:2]      b_addr,
  input  logic [31:0]      b_wdata,
  output logic             b_ack,
  output logic [31:0]      b_rdata,
  output logic [11:2]      mem_addr,
  output logic [31:0]      mem_din,
  output logic             mem_we,
  input  logic [31:0]      mem_dout,
  output logic             busy,
  output logic [CNT_W-1:0] acc_cnt
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;   // last winner: 1 = B
  logic             sel_q, sel_d;     // current owner: 1 = B
  logic             we_q, we_d;
  logic [11:2]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      a_rdata_q, b_rdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             grant_b;
  logic             in_access;
  logic             in_done;

  // On a tie the port that did not win last time gets the grant.
  assign grant_b = b_req & (~a_req | ~last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (a_req | b_req) begin
          state_d = StAccess;
          sel_d   = grant_b;
          last_d  = grant_b;
          we_d    = grant_b ? b_we    : a_we;
          addr_d  = grant_b ? b_addr  : a_addr;
          wdata_d = grant_b ? b_wdata : a_wdata;
        end
      end
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (in_access && !we_q) begin
        if (sel_q) b_rdata_q <= mem_dout;
        else       a_rdata_q <= mem_dout;
      end
      if (in_done && (cnt_q != '1)) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign in_access = (state_q == StAccess);
  assign in_done   = (state_q == StDone);

  // Memory bus is quiet outside ACCESS; a reset edge suppresses the write.
  assign mem_addr = in_access ? addr_q  : '0;
  assign mem_din  = in_access ? wdata_q : '0;
  assign mem_we   = in_access & we_q & ~rst;

  assign a_ack   = in_done & ~sel_q;
  assign b_ack   = in_done &  sel_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
  assign busy    = (state_q != StIdle);
  assign acc_cnt = cnt_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: self-checking bench for dm_arbiter. Main instance uses CNT_W=16,
// a second instance with CNT_W=2 shares all inputs to check counter saturation.
module tb_dm_arbiter;

  logic        clk, rst;
  logic        a_req, a_we, b_req, b_we;
  logic [11:2] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_ack, b_ack, mem_we, busy;
  logic [31:0] a_rdata, b_rdata, mem_din, mem_dout;
  logic [11:2] mem_addr;
  logic [15:0] acc_cnt;

  logic        a_ack2, b_ack2, mem_we2, busy2;
  logic [31:0] a_rdata2, b_rdata2, mem_din2;
  logic [11:2] mem_addr2;
  logic [1:0]  acc_cnt2;

  logic [31:0] ram [1024];
  logic        pre_en;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  int n_checks = 0;
  int n_pass   = 0;

  dm_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .busy(busy), .acc_cnt(acc_cnt)
  );

  dm_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack2), .a_rdata(a_rdata2),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack2), .b_rdata(b_rdata2),
    .mem_addr(mem_addr2), .mem_din(mem_din2), .mem_we(mem_we2), .mem_dout(mem_dout),
    .busy(busy2), .acc_cnt(acc_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the clock edge.
  assign mem_dout = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    if (pre_en) ram[pre_addr] <= pre_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] addr, input logic [31:0] data);
    pre_en = 1'b1; pre_addr = addr; pre_data = data;
    step();
    pre_en = 1'b0;
  endtask

  task automatic drive_idle();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One single-port transaction from IDLE; ends in the IDLE cycle after DONE.
  task automatic txn(input bit port, input bit we, input logic [9:0] addr,
                     input logic [31:0] data, input logic [31:0] exp_rd, input string tag);
    logic [31:0] rd;
    if (port == 0) begin a_req = 1; a_we = we; a_addr = addr; a_wdata = data; end
    else           begin b_req = 1; b_we = we; b_addr = addr; b_wdata = data; end
    step();
    n_checks++;
    if ({busy, mem_we, mem_addr, mem_din, a_ack, b_ack} !== {1'b1, we, addr, data, 2'b00})
      $display("FAIL %s_access: busy=%0b we=%0b addr=%h din=%h acks=%0b%0b want 1 %0b %h %h 00",
               tag, busy, mem_we, mem_addr, mem_din, a_ack, b_ack, we, addr, data);
    else n_pass++;
    step();
    n_checks++;
    if ({a_ack, b_ack, mem_we, busy} !== {~port, port, 1'b0, 1'b1})
      $display("FAIL %s_ack: a_ack=%0b b_ack=%0b mem_we=%0b busy=%0b want %0b %0b 0 1",
               tag, a_ack, b_ack, mem_we, busy, ~port, port);
    else n_pass++;
    if (!we) begin
      rd = port ? b_rdata : a_rdata;
      n_checks++;
      if (rd !== exp_rd) $display("FAIL %s_rdata: got %h want %h", tag, rd, exp_rd);
      else n_pass++;
    end
    a_req = 0; b_req = 0;
    step();
    n_checks++;
    if ({busy, a_ack, b_ack} !== 3'b000)
      $display("FAIL %s_idle: busy=%0b acks=%0b%0b want 0 00", tag, busy, a_ack, b_ack);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({a_ack, b_ack, mem_we, busy, mem_addr, mem_din, acc_cnt, a_rdata, b_rdata,
           acc_cnt2} !== '0)
        $display("FAIL reset_idle%0d: acks=%0b%0b we=%0b busy=%0b addr=%h din=%h cnt=%0d ard=%h brd=%h cnt2=%0d want all 0",
                 i, a_ack, b_ack, mem_we, busy, mem_addr, mem_din, acc_cnt, a_rdata, b_rdata,
                 acc_cnt2);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_write_read();
    txn(0, 1, 10'h004, 32'hDEADBEEF, 32'h0, "a_write");
    n_checks++;
    if (ram[10'h004] !== 32'hDEADBEEF)
      $display("FAIL a_write_mem: got %h want deadbeef", ram[10'h004]);
    else n_pass++;
    txn(0, 0, 10'h004, 32'h0, 32'hDEADBEEF, "a_read");
    n_checks++;
    if (acc_cnt !== 16'd2) $display("FAIL wr_rd_cnt: got %0d want 2", acc_cnt);
    else n_pass++;
  endtask

  task automatic test_b_read();
    preload(10'h3FF, 32'h12345678);
    txn(1, 0, 10'h3FF, 32'h0, 32'h12345678, "b_read");
    n_checks++;
    if (a_rdata !== 32'hDEADBEEF) $display("FAIL b_read_a_hold: got %h want deadbeef", a_rdata);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    bit order[$];
    bit exp_order[4] = '{0, 1, 0, 1};
    do_reset();
    preload(10'h001, 32'hA1A1A1A1);
    preload(10'h002, 32'hB2B2B2B2);
    a_req = 1; a_we = 0; a_addr = 10'h001;
    b_req = 1; b_we = 0; b_addr = 10'h002;
    for (int i = 0; i < 12; i++) begin
      step();
      n_checks++;
      if (a_ack && b_ack) $display("FAIL rr_both_ack: cycle %0d a_ack=1 b_ack=1 want not both", i);
      else n_pass++;
      if (a_ack) order.push_back(1'b0);
      if (b_ack) order.push_back(1'b1);
    end
    drive_idle();
    step();
    n_checks++;
    if (order.size() != 4) $display("FAIL rr_count: got %0d acks want 4", order.size());
    else n_pass++;
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      n_checks++;
      if (order[i] !== exp_order[i])
        $display("FAIL rr_order%0d: got %s want %s", i, order[i] ? "B" : "A",
                 exp_order[i] ? "B" : "A");
      else n_pass++;
    end
    n_checks++;
    if ({a_rdata, b_rdata} !== {32'hA1A1A1A1, 32'hB2B2B2B2})
      $display("FAIL rr_rdata: got %h %h want a1a1a1a1 b2b2b2b2", a_rdata, b_rdata);
    else n_pass++;
  endtask

  task automatic test_rst_abort();
    do_reset();
    preload(10'h010, 32'h0BADC0DE);
    a_req = 1; a_we = 1; a_addr = 10'h010; a_wdata = 32'hCAFEF00D;
    step();
    n_checks++;
    if ({busy, mem_we} !== 2'b11) $display("FAIL abort_access: busy=%0b we=%0b want 1 1", busy, mem_we);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_we !== 1'b0) $display("FAIL abort_we: got %0b want 0", mem_we);
    else n_pass++;
    a_req = 0;
    step();
    rst = 1'b0;
    n_checks++;
    if ({busy, a_ack, ram[10'h010]} !== {2'b00, 32'h0BADC0DE})
      $display("FAIL abort_state: busy=%0b a_ack=%0b mem=%h want 0 0 0badc0de",
               busy, a_ack, ram[10'h010]);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if ({a_ack, busy, acc_cnt} !== '0)
        $display("FAIL abort_noack%0d: a_ack=%0b busy=%0b cnt=%0d want 0 0 0", i, a_ack, busy, acc_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_cnt_sat();
    logic [1:0] exp_seq[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      txn(0, 0, 10'h001, 32'h0, 32'hA1A1A1A1, "sat_rd");
      n_checks++;
      if (acc_cnt2 !== exp_seq[k] || acc_cnt !== 16'(k + 1))
        $display("FAIL cnt_sat%0d: cnt2=%0d cnt=%0d want %0d %0d", k, acc_cnt2, acc_cnt,
                 exp_seq[k], k + 1);
      else n_pass++;
    end
  endtask

  // Random two-port traffic against a transaction-level model: each grant takes
  // three cycles (grant, memory access, ack), ties alternate, memory is an array.
  task automatic test_random();
    logic [31:0] ref_mem[16];
    bit          pend[2];
    bit          p_we[2];
    logic [9:0]  p_addr[2];
    logic [31:0] p_data[2];
    logic [31:0] exp_rd[2];
    bit          last_b, win, g_we;
    logic [9:0]  g_addr;
    logic [31:0] g_data;
    int          since, done_cnt;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      preload(10'(i), ref_mem[i]);
    end
    pend = '{0, 0}; exp_rd = '{32'h0, 32'h0};
    last_b = 1; win = 0; since = 0; done_cnt = 0;
    g_we = 0; g_addr = '0; g_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_checks++;
      if (a_ack !== (since == 2 && !win) || b_ack !== (since == 2 && win) ||
          busy !== (since != 0))
        $display("FAIL rnd_ctl c%0d: a_ack=%0b b_ack=%0b busy=%0b phase=%0d win=%0b",
                 cyc, a_ack, b_ack, busy, since, win);
      else n_pass++;
      n_checks++;
      if (mem_we !== (since == 1 && g_we) || mem_addr !== (since == 1 ? g_addr : 10'h0))
        $display("FAIL rnd_mem c%0d: we=%0b addr=%h phase=%0d want we=%0b addr=%h",
                 cyc, mem_we, mem_addr, since, g_we, g_addr);
      else n_pass++;
      n_checks++;
      if (a_rdata !== exp_rd[0] || b_rdata !== exp_rd[1] || acc_cnt !== 16'(done_cnt))
        $display("FAIL rnd_data c%0d: ard=%h brd=%h cnt=%0d want %h %h %0d", cyc,
                 a_rdata, b_rdata, acc_cnt, exp_rd[0], exp_rd[1], done_cnt);
      else n_pass++;
      if (since == 2) begin
        pend[win] = 0;
        done_cnt++;
      end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 1) == 1) begin
          pend[p]   = 1;
          p_we[p]   = 1'($urandom_range(0, 1));
          p_addr[p] = 10'($urandom_range(0, 15));
          p_data[p] = $urandom;
        end
      end
      a_req = pend[0]; b_req = pend[1];
      a_we    = pend[0] ? p_we[0]   : 1'($urandom_range(0, 1));
      a_addr  = pend[0] ? p_addr[0] : 10'($urandom);
      a_wdata = pend[0] ? p_data[0] : $urandom;
      b_we    = pend[1] ? p_we[1]   : 1'($urandom_range(0, 1));
      b_addr  = pend[1] ? p_addr[1] : 10'($urandom);
      b_wdata = pend[1] ? p_data[1] : $urandom;
      if (since == 2) begin
        since = 0;
      end else if (since == 1) begin
        if (g_we) ref_mem[g_addr[3:0]] = g_data;
        else      exp_rd[win] = ref_mem[g_addr[3:0]];
        since = 2;
      end else if (pend[0] || pend[1]) begin
        if (pend[0] && pend[1]) win = ~last_b;
        else                    win = pend[1];
        last_b = win;
        g_we = p_we[win]; g_addr = p_addr[win]; g_data = p_data[win];
        since = 1;
      end
      step();
    end
    drive_idle();
  endtask

  initial begin
    pre_en = 0; pre_addr = '0; pre_data = '0;
    rst = 1'b0;
    drive_idle();
    test_reset();
    test_write_read();
    test_b_read();
    test_round_robin();
    test_rst_abort();
    test_cnt_sat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
